// File: rtl/wb_stage_pipe.sv
// MEM/WB register, result select, load extraction, retire counter.
// Optional byte/halfword extraction: define WB_LOAD_EXT_EN.
module wb_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              mvalid,
   input  logic              mwreg,
   input  logic              mm2reg,
   input  logic [REG_AW-1:0] mrn,
   input  logic [DATA_W-1:0] malu,
   input  logic [DATA_W-1:0] mmo,
   input  logic [2:0]        mld_type,
   input  logic              wb_stall,
   input  logic              wb_flush,
   output logic              wwreg,
   output logic [REG_AW-1:0] wrn,
   output logic [DATA_W-1:0] wdi,
   output logic [31:0]       wretire
);

   logic              valid_q, valid_d;
   logic              wreg_q, wreg_d;
   logic              m2reg_q, m2reg_d;
   logic [REG_AW-1:0] rn_q, rn_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] mo_q, mo_d;
   logic [31:0]       retire_q, retire_d;
   logic [DATA_W-1:0] ext_mo;

`ifdef WB_LOAD_EXT_EN
   logic [2:0]        ld_type_q, ld_type_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [OFF_W-1:0]  hidx;
   logic [DATA_W-1:0] sh_b, sh_h;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
`else
   logic unused_ext;
   assign unused_ext = ^{mld_type, malu[OFF_W-1:0]};
`endif

   always_comb begin
      valid_d  = valid_q;
      wreg_d   = wreg_q;
      m2reg_d  = m2reg_q;
      rn_d     = rn_q;
      alu_d    = alu_q;
      mo_d     = mo_q;
      retire_d = retire_q;
`ifdef WB_LOAD_EXT_EN
      ld_type_d = ld_type_q;
      off_d     = off_q;
`endif
      if (wb_flush) begin
         valid_d = 1'b0;
         wreg_d  = 1'b0;
         m2reg_d = 1'b0;
         rn_d    = '0;
         alu_d   = '0;
         mo_d    = '0;
`ifdef WB_LOAD_EXT_EN
         ld_type_d = '0;
         off_d     = '0;
`endif
      end else if (!wb_stall) begin
         valid_d = mvalid;
         wreg_d  = mwreg;
         m2reg_d = mm2reg;
         rn_d    = mrn;
         alu_d   = malu;
         mo_d    = mmo;
`ifdef WB_LOAD_EXT_EN
         ld_type_d = mld_type;
         off_d     = malu[OFF_W-1:0];
`endif
         if (mvalid) retire_d = retire_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         valid_q  <= 1'b0;
         wreg_q   <= 1'b0;
         m2reg_q  <= 1'b0;
         rn_q     <= '0;
         alu_q    <= '0;
         mo_q     <= '0;
         retire_q <= '0;
      end else begin
         valid_q  <= valid_d;
         wreg_q   <= wreg_d;
         m2reg_q  <= m2reg_d;
         rn_q     <= rn_d;
         alu_q    <= alu_d;
         mo_q     <= mo_d;
         retire_q <= retire_d;
      end
   end

`ifdef WB_LOAD_EXT_EN
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ld_type_q <= '0;
         off_q     <= '0;
      end else begin
         ld_type_q <= ld_type_d;
         off_q     <= off_d;
      end
   end

   // Little-endian lanes; halfword index drops off[0].
   always_comb begin
      hidx   = off_q >> 1;
      sh_b   = mo_q >> {off_q, 3'b000};
      sh_h   = mo_q >> {hidx, 4'b0000};
      byte_v = sh_b[7:0];
      half_v = sh_h[15:0];
      case (ld_type_q)
         3'b001:  ext_mo = {{(DATA_W-8){byte_v[7]}}, byte_v};
         3'b010:  ext_mo = {{(DATA_W-8){1'b0}}, byte_v};
         3'b011:  ext_mo = {{(DATA_W-16){half_v[15]}}, half_v};
         3'b100:  ext_mo = {{(DATA_W-16){1'b0}}, half_v};
         default: ext_mo = mo_q;
      endcase
   end
`else
   assign ext_mo = mo_q;
`endif

   assign wwreg   = valid_q & wreg_q & (rn_q != '0);
   assign wrn     = rn_q;
   assign wdi     = m2reg_q ? ext_mo : alu_q;
   assign wretire = retire_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomized bench for wb_stage_pipe against a behavioural model.
// Expectations follow WB_LOAD_EXT_EN when defined.
module tb_wb_stage_pipe;

   logic        clk = 1'b0;
   logic        clrn;
   logic        mvalid, mwreg, mm2reg;
   logic [4:0]  mrn;
   logic [31:0] malu, mmo;
   logic [2:0]  mld_type;
   logic        wb_stall, wb_flush;
   logic        wwreg;
   logic [4:0]  wrn;
   logic [31:0] wdi, wretire;

   int total = 0;
   int bad   = 0;

   logic        e_ww;
   logic [4:0]  e_rn;
   logic [31:0] e_wdi, e_cnt;

   always #5 clk = ~clk;

   wb_stage_pipe dut (
      .clk(clk), .clrn(clrn), .mvalid(mvalid), .mwreg(mwreg),
      .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
      .mld_type(mld_type), .wb_stall(wb_stall), .wb_flush(wb_flush),
      .wwreg(wwreg), .wrn(wrn), .wdi(wdi), .wretire(wretire)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [2:0] t,
                                           input logic [31:0] mo,
                                           input logic [31:0] a);
`ifdef WB_LOAD_EXT_EN
      int off, b, h, r;
      off = int'(a % 4);
      b   = int'((mo >> (8 * off)) % 256);
      h   = int'((mo >> (16 * (off / 2))) % 65536);
      case (t)
         3'd1:    r = (b >= 128) ? b - 256 : b;
         3'd2:    r = b;
         3'd3:    r = (h >= 32768) ? h - 65536 : h;
         3'd4:    r = h;
         default: return mo;
      endcase
      return 32'(r);
`else
      return mo;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".wwreg"}, 32'(wwreg), 32'(e_ww));
      chk({tag, ".wrn"}, 32'(wrn), 32'(e_rn));
      chk({tag, ".wdi"}, wdi, e_wdi);
      chk({tag, ".ret"}, wretire, e_cnt);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (wb_flush) begin
         e_ww = 1'b0; e_rn = '0; e_wdi = '0;
      end else if (!wb_stall) begin
         e_ww  = mvalid && mwreg && (mrn != 0);
         e_rn  = mrn;
         e_wdi = mm2reg ? ref_ext(mld_type, mmo, malu) : malu;
         if (mvalid) e_cnt = e_cnt + 1;
      end
      #1 check_all(tag);
   endtask

   task automatic drive(input logic v, input logic w, input logic m2,
                        input logic [4:0] rn, input logic [31:0] a,
                        input logic [31:0] mo, input logic [2:0] t);
      mvalid = v; mwreg = w; mm2reg = m2; mrn = rn;
      malu = a; mmo = mo; mld_type = t;
   endtask

   task automatic model_reset();
      e_ww = 1'b0; e_rn = '0; e_wdi = '0; e_cnt = '0;
   endtask

   initial begin
      clrn = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
      drive(1, 1, 0, 5'd3, 32'h1, 32'h2, 3'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all("reset");
      @(negedge clk) clrn = 1'b1;

      drive(1, 1, 0, 5'd8, 32'h1234_5678, 32'h0, 3'd0);
      step("alu");
      chk("alu.const", wdi, 32'h1234_5678);
      chk("alu.ret1", wretire, 32'd1);

      @(negedge clk) drive(1, 1, 1, 5'd9, 32'h3, 32'h80AA_BBCC, 3'd1);
      step("lb");
`ifdef WB_LOAD_EXT_EN
      chk("lb.const", wdi, 32'hFFFF_FF80);
`else
      chk("lb.const", wdi, 32'h80AA_BBCC);
`endif
      @(negedge clk) mld_type = 3'd2;
      step("lbu");
      @(negedge clk) begin mld_type = 3'd3; malu = 32'h2; end
      step("lh");
      @(negedge clk) begin mld_type = 3'd4; malu = 32'h0; end
      step("lhu");
`ifdef WB_LOAD_EXT_EN
      chk("lhu.const", wdi, 32'h0000_BBCC);
`else
      chk("lhu.const", wdi, 32'h80AA_BBCC);
`endif

      @(negedge clk) drive(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 3'd0);
      step("zero");
      chk("zero.ww", 32'(wwreg), 32'd0);

      @(negedge clk) drive(1, 1, 0, 5'd17, 32'hA5A5_0001, 32'h0, 3'd0);
      step("ldA");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wb_stall = 1'b1;
         drive(1, 1, 1, 5'($urandom), $urandom, $urandom, 3'($urandom));
         step("stall");
      end
      chk("stall.hold", wdi, 32'hA5A5_0001);
      @(negedge clk) wb_flush = 1'b1;
      step("stfl");
      @(negedge clk) begin wb_stall = 1'b0; wb_flush = 1'b0; end

      @(negedge clk);
      force dut.retire_q = 32'hFFFF_FFFF;
      #1 release dut.retire_q;
      e_cnt = 32'hFFFF_FFFF;
      drive(1, 0, 0, 5'd1, 32'h7, 32'h0, 3'd0);
      step("wrap");

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), $urandom, $urandom,
               3'($urandom_range(0, 7)));
         wb_stall = ($urandom_range(0, 4) == 0);
         wb_flush = ($urandom_range(0, 7) == 0);
         step("rnd");
      end

      @(negedge clk) begin
         wb_stall = 1'b0; wb_flush = 1'b0;
         drive(1, 1, 0, 5'd4, 32'h55AA_55AA, 32'h0, 3'd0);
      end
      step("pre_rst");
      #2 clrn = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      @(negedge clk) clrn = 1'b1;
      step("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised write-back stage for the 5-stage MIPS pipeline: owns the MEM/WB pipeline register, selects ALU result vs. load data, and performs byte/halfword load extraction with sign/zero extension. It drives the register-file write port (`wwreg`, `wrn`, `wdi`) and a retired-instruction counter. Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; power of two, ≥16.
- `REG_AW`, 5, register-number width.
- `OFF_W`, log2(DATA_W/8), derived; byte-offset width.

Ports:
- `clk` in 1: clock, rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `mvalid` in 1: M-stage slot holds a real instruction.
- `mwreg` in 1: M-stage instruction writes the register file.
- `mm2reg` in 1: 1 = write load data, 0 = write ALU result.
- `mrn` in REG_AW: destination register.
- `malu` in DATA_W: ALU result / effective address.
- `mmo` in DATA_W: data-memory read word.
- `mld_type` in 3: load type (000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others = LW).
- `wb_stall` in 1: hold the W register.
- `wb_flush` in 1: load a bubble into the W register.
- `wwreg` out 1: register-file write enable.
- `wrn` out REG_AW: register-file write address.
- `wdi` out DATA_W: register-file write data.
- `wretire` out 32: retired-instruction count.

## Operation
- W register fields: valid, wreg, m2reg, rn, alu, mo, ld_type, off (= `malu[OFF_W-1:0]`).
- Each rising edge, priority: `wb_flush` > `wb_stall` > load.
  - flush: valid=0, wreg=0; other fields don't-care (cleared to 0).
  - stall: all fields hold.
  - load: all fields captured from M inputs.
- `wwreg` = valid & wreg & (rn ≠ 0); writes to $zero always suppressed.
- `wrn` = rn.
- `wdi` = m2reg ? ext(mo) : alu; combinational from the W register, independent of `wwreg`.
- ext(mo), little-endian lanes:
  - LB/LBU: byte k = off, bits [8k+7:8k]; sign- / zero-extended to DATA_W.
  - LH/LHU: half h = off[OFF_W-1:1], bits [16h+15:16h]; sign- / zero-extended; off[0] ignored (no misalignment trap).
  - LW/others: mo unchanged.
- `wretire` increments by 1 on each edge where load is taken (no flush, no stall) and `mvalid`=1; wraps 2^32−1 → 0.

## Timing
- Latency: M inputs → `wwreg`/`wrn`/`wdi` one cycle (registered on the edge, settled after clk-to-q plus mux/extend logic).
- `wretire` reflects the edge on which the instruction entered W.
- Reset (`clrn`=0, any time, incl. mid-stall): all W fields 0, `wretire`=0, so `wwreg`=0, `wrn`=0, `wdi`=0; held until `clrn` rises, first capture on the next rising edge.
- Stall with flush asserted in the same cycle: flush wins, counter does not increment.
- Stall for N cycles: outputs constant for N cycles; `wwreg` stays asserted (regfile rewrite of identical data is benign).

## Configuration
- `WB_LOAD_EXT_EN` defined: byte/halfword extraction and extension as above.
- Not defined: ext(mo) = mo for every `mld_type`; `mld_type` and off unused (no extraction logic synthesised); all else identical.

## Test plan
- ALU write: mvalid=1, mwreg=1, mm2reg=0, mrn=8, malu=0x1234_5678 → next cycle wwreg=1, wrn=8, wdi=0x1234_5678, wretire=1.
- LB sign: mm2reg=1, mld_type=001, malu=0x...03, mmo=0x80AA_BBCC → wdi=0xFFFF_FF80; LBU same → 0x0000_0080; LH off=2 → 0xFFFF_80AA; LHU off=0 → 0x0000_BBCC (macro defined); undefined macro → 0x80AA_BBCC for all.
- $zero: mwreg=1, mrn=0 → wwreg=0, wretire still increments.
- Stall/flush: load instr A, stall 3 cycles while M changes → outputs hold A, wretire unchanged; assert stall+flush together → wwreg=0, wretire unchanged.
- Reset mid-operation: drop clrn asynchronously between edges with wwreg=1 → wwreg, wrn, wdi, wretire = 0 immediately.
- Counter wrap: force 2^32−1 retirements (or preload via hierarchical force) → next retire gives wretire=0.
